// File: rtl/tx_word_scheduler.sv
// Round-robin framer sharing the byte-serial link between two word sources.
// Each frame is one header word plus BURST data words, sent MSB byte first.
module tx_word_scheduler #(
    parameter int          BURST    = 8,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int          ACK_TO   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] src0_data,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [31:0] src1_data,
    input  logic        src1_valid,
    output logic        src1_ready,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        is_transmitting,
    output logic        busy,
    output logic        grant,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, ISSUE, ACK, DONE
    } state_t;

    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);
    localparam logic [7:0] BURST_LEN = 8'(BURST);

    state_t      state;
    state_t      stateNext;
    logic [31:0] wordBuf;
    logic [1:0]  idx;
    logic [7:0]  wordCnt;
    logic [7:0]  ackCnt;
    logic [15:0] seq;
    logic        prio;
    logic        pick;
    logic        accept;
    logic        ackTimeout;

    always_comb begin
        pick = src1_valid;
        if (src0_valid && src1_valid) begin
            pick = prio;
        end
    end

    assign accept = grant ? (src1_valid && src1_ready)
                          : (src0_valid && src0_ready);

    assign ackTimeout = !is_transmitting && (ackCnt == ACK_LAST);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (enable && (src0_valid || src1_valid)) begin
                    stateNext = HDR;
                end
            end
            HDR:   stateNext = ISSUE;
            ISSUE: stateNext = ACK;
            ACK: begin
                if (is_transmitting) begin
                    stateNext = DONE;
                end else if (ackTimeout) begin
                    stateNext = IDLE;
                end
            end
            DONE: begin
                if (!is_transmitting) begin
                    if (idx != 2'd0) begin
                        stateNext = ISSUE;
                    end else if (wordCnt < BURST_LEN) begin
                        stateNext = FETCH;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            FETCH: begin
                if (accept) begin
                    stateNext = ISSUE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wordBuf    <= '0;
            idx        <= '0;
            wordCnt    <= '0;
            ackCnt     <= '0;
            seq        <= '0;
            prio       <= 1'b0;
            tx_byte    <= '0;
            transmit   <= 1'b0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            error      <= 1'b0;
            src0_ready <= 1'b0;
            src1_ready <= 1'b0;
        end else begin
            state      <= stateNext;
            transmit   <= (state == ISSUE);
            busy       <= (stateNext != IDLE);
            src0_ready <= (stateNext == FETCH) && !grant;
            src1_ready <= (stateNext == FETCH) && grant;
            unique case (state)
                IDLE: begin
                    if (stateNext == HDR) begin
                        grant <= pick;
                    end
                end
                HDR: begin
                    wordBuf <= {HDR_BYTE, 7'd0, grant, seq};
                    idx     <= 2'd3;
                    wordCnt <= '0;
                end
                ISSUE: begin
                    tx_byte <= wordBuf[{idx, 3'b000} +: 8];
                    ackCnt  <= '0;
                end
                ACK: begin
                    ackCnt <= ackCnt + 8'd1;
                    if (ackTimeout) begin
                        error <= 1'b1;
                    end
                end
                DONE: begin
                    if (!is_transmitting) begin
                        if (idx != 2'd0) begin
                            idx <= idx - 2'd1;
                        end else if (wordCnt >= BURST_LEN) begin
                            seq  <= seq + 16'd1;
                            prio <= ~grant;
                        end
                    end
                end
                FETCH: begin
                    if (accept) begin
                        wordBuf <= grant ? src1_data : src0_data;
                        idx     <= 2'd3;
                        wordCnt <= wordCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Scoreboard bench for tx_word_scheduler with a simple serializer model.
// Expected {grant, byte} pairs are queued by the stimulus, popped on transmit.
module tb_tx_word_scheduler;

    localparam int BURST  = 2;
    localparam int ACK_TO = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] src0_data;
    logic        src0_valid;
    logic        src0_ready;
    logic [31:0] src1_data;
    logic        src1_valid;
    logic        src1_ready;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting;
    logic        busy;
    logic        grant;
    logic        error;

    tx_word_scheduler #(
        .BURST(BURST),
        .HDR_BYTE(8'hA5),
        .ACK_TO(ACK_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .src0_data(src0_data),
        .src0_valid(src0_valid),
        .src0_ready(src0_ready),
        .src1_data(src1_data),
        .src1_valid(src1_valid),
        .src1_ready(src1_ready),
        .tx_byte(tx_byte),
        .transmit(transmit),
        .is_transmitting(is_transmitting),
        .busy(busy),
        .grant(grant),
        .error(error)
    );

    int          errors = 0;
    int          checks = 0;
    int          txCount = 0;
    logic [8:0]  expQ[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        gate0 = 0;
    logic        gate1 = 0;
    logic        serMute = 0;
    logic        prevTx = 0;
    int          serCnt = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushWord(input logic g, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            expQ.push_back({g, w[8*i +: 8]});
        end
    endtask

    // Serializer: busy for 3 cycles after each accepted transmit
    always @(posedge clk) begin
        if (rst) begin
            is_transmitting <= 1'b0;
            serCnt <= 0;
        end else if (serCnt != 0) begin
            serCnt <= serCnt - 1;
            if (serCnt == 1) is_transmitting <= 1'b0;
        end else if (transmit && !serMute) begin
            is_transmitting <= 1'b1;
            serCnt <= 3;
        end
    end

    always @(posedge clk) begin
        if (src0_valid && src0_ready && q0.size() != 0) void'(q0.pop_front());
        if (src1_valid && src1_ready && q1.size() != 0) void'(q1.pop_front());
    end

    always @(negedge clk) begin
        src0_valid = gate0 && (q0.size() != 0);
        src0_data  = (q0.size() != 0) ? q0[0] : 32'd0;
        src1_valid = gate1 && (q1.size() != 0);
        src1_data  = (q1.size() != 0) ? q1[0] : 32'd0;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (transmit) begin
                txCount++;
                chk("tx_while_busy", 32'(is_transmitting), 32'd0);
                chk("tx_back_to_back", 32'(prevTx), 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h grant %0d expected none",
                             tx_byte, grant);
                end else begin
                    e = expQ.pop_front();
                    chk("tx_byte", 32'(tx_byte), 32'(e[7:0]));
                    chk("tx_grant", 32'(grant), 32'(e[8]));
                end
            end
            if (busy) begin
                chk("ready_isolation", 32'(grant ? src0_ready : src1_ready), 32'd0);
            end
        end
        prevTx = transmit;
    end

    task automatic resetDut();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        expQ.delete();
    endtask

    task automatic waitFrame(input string name);
        bit seen = 0;
        bit ended = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (busy) seen = 1;
            else if (seen) begin
                ended = 1;
                break;
            end
        end
        chk(name, 32'(ended), 32'd1);
    endtask

    task automatic checkOutputsZero(input string tag);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_transmit"}, 32'(transmit), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_ready0"}, 32'(src0_ready), 32'd0);
        chk({tag, "_ready1"}, 32'(src1_ready), 32'd0);
    endtask

    initial begin
        int base;
        int cnt;
        bit hit;
        rst = 1;
        enable = 0;
        repeat (2) @(negedge clk);
        checkOutputsZero("reset");
        rst = 0;

        // T1: single source frame, then a second frame shows seq advanced
        pushWord(0, 32'hA5000000);
        pushWord(0, 32'h01020304);
        pushWord(0, 32'h05060708);
        q0.push_back(32'h01020304);
        q0.push_back(32'h05060708);
        gate0 = 1;
        enable = 1;
        base = txCount;
        waitFrame("t1_frame");
        chk("t1_pending", 32'(expQ.size()), 32'd0);
        chk("t1_bytes", 32'(txCount - base), 32'd12);
        chk("t1_busy_after", 32'(busy), 32'd0);
        pushWord(0, 32'hA5000001);
        pushWord(0, 32'h0A0B0C0D);
        pushWord(0, 32'h0E0F1011);
        q0.push_back(32'h0A0B0C0D);
        q0.push_back(32'h0E0F1011);
        waitFrame("t1_seq1_frame");
        chk("t1_seq1_pending", 32'(expQ.size()), 32'd0);

        // T2: both sources valid, round-robin 0,1,0
        resetDut();
        pushWord(0, 32'hA5000000);
        pushWord(0, 32'h10000001);
        pushWord(0, 32'h10000002);
        pushWord(1, 32'hA5010001);
        pushWord(1, 32'h20000001);
        pushWord(1, 32'h20000002);
        pushWord(0, 32'hA5000002);
        pushWord(0, 32'h10000003);
        pushWord(0, 32'h10000004);
        q0.push_back(32'h10000001);
        q0.push_back(32'h10000002);
        q0.push_back(32'h10000003);
        q0.push_back(32'h10000004);
        q1.push_back(32'h20000001);
        q1.push_back(32'h20000002);
        gate1 = 1;
        waitFrame("t2_frame0");
        waitFrame("t2_frame1");
        waitFrame("t2_frame2");
        chk("t2_pending", 32'(expQ.size()), 32'd0);

        // T3: source 0 stalls 50 cycles mid-burst
        resetDut();
        pushWord(0, 32'hA5000000);
        pushWord(0, 32'h30000001);
        q0.push_back(32'h30000001);
        q1.push_back(32'h40000001);
        q1.push_back(32'h40000002);
        hit = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                hit = 1;
                break;
            end
        end
        chk("t3_first_word", 32'(hit), 32'd1);
        base = txCount;
        repeat (50) @(negedge clk);
        chk("t3_gap_no_tx", 32'(txCount - base), 32'd0);
        chk("t3_gap_busy", 32'(busy), 32'd1);
        pushWord(0, 32'h30000002);
        pushWord(1, 32'hA5010001);
        pushWord(1, 32'h40000001);
        pushWord(1, 32'h40000002);
        q0.push_back(32'h30000002);
        waitFrame("t3_frame0");
        waitFrame("t3_frame1");
        chk("t3_pending", 32'(expQ.size()), 32'd0);

        // T4: serializer never acknowledges
        resetDut();
        gate1 = 0;
        serMute = 1;
        pushWord(0, 32'hA5000000);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        q0.push_back(32'h50000001);
        hit = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (transmit) begin
                hit = 1;
                break;
            end
        end
        chk("t4_first_tx", 32'(hit), 32'd1);
        gate0 = 0;
        cnt = 0;
        while (!error && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("t4_timeout_cycles", 32'(cnt), 32'(ACK_TO));
        chk("t4_idle", 32'(busy), 32'd0);
        serMute = 0;
        pushWord(0, 32'hA5000000);
        pushWord(0, 32'h50000001);
        pushWord(0, 32'h50000002);
        q0.push_back(32'h50000002);
        gate0 = 1;
        waitFrame("t4_retry_frame");
        chk("t4_pending", 32'(expQ.size()), 32'd0);
        chk("t4_error_sticky", 32'(error), 32'd1);

        // T5: reset during byte 2 of a data word
        resetDut();
        pushWord(0, 32'hA5000000);
        expQ.push_back({1'b0, 8'h60});
        expQ.push_back({1'b0, 8'h00});
        q0.push_back(32'h60000001);
        q0.push_back(32'h60000002);
        base = txCount;
        hit = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (txCount - base >= 6) begin
                hit = 1;
                break;
            end
        end
        chk("t5_reach_byte2", 32'(hit), 32'd1);
        rst = 1;
        gate0 = 0;
        q0.delete();
        @(negedge clk);
        checkOutputsZero("t5_abort");
        rst = 0;
        chk("t5_pending", 32'(expQ.size()), 32'd0);
        pushWord(0, 32'hA5000000);
        pushWord(0, 32'h70000001);
        pushWord(0, 32'h70000002);
        q0.push_back(32'h70000001);
        q0.push_back(32'h70000002);
        gate0 = 1;
        waitFrame("t5_new_frame");
        chk("t5_new_pending", 32'(expQ.size()), 32'd0);

        // T6: enable gating in IDLE only
        enable = 0;
        q0.push_back(32'h80000001);
        q0.push_back(32'h80000002);
        base = txCount;
        repeat (30) @(negedge clk);
        chk("t6_disabled_no_tx", 32'(txCount - base), 32'd0);
        chk("t6_disabled_idle", 32'(busy), 32'd0);
        pushWord(0, 32'hA5000001);
        pushWord(0, 32'h80000001);
        pushWord(0, 32'h80000002);
        enable = 1;
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) begin
                hit = 1;
                break;
            end
        end
        chk("t6_started", 32'(hit), 32'd1);
        enable = 0;
        waitFrame("t6_frame");
        chk("t6_bytes", 32'(txCount - base), 32'(4 * (1 + BURST)));
        chk("t6_pending", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
